// File: rtl/ham_7_4_pkg.sv
// ============================================================================
// Module  : ham_7_4_pkg
// Brief   : Types and syndrome/correction functions for the Hamming(7,4) decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ham_7_4_pkg;

    typedef logic [7:1] code7_t;
    typedef logic [1:4] data4_t;
    typedef logic [2:0] synd_t;

    // Codeword layout {p1,p2,d1,p3,d2,d3,d4} at c7..c1; result is {s3,s2,s1}.
    function automatic synd_t ham74_syndrome(input code7_t c);
        return {c[4] ^ c[3] ^ c[2] ^ c[1],
                c[6] ^ c[5] ^ c[2] ^ c[1],
                c[7] ^ c[5] ^ c[3] ^ c[1]};
    endfunction

    // Syndrome k names the flipped bit c[8-k]; parity-only positions leave data intact.
    function automatic data4_t ham74_correct(input code7_t c, input synd_t s);
        code7_t f;
        f = c;
        case (s)
            3'd3:    f[5] = ~f[5];
            3'd5:    f[3] = ~f[3];
            3'd6:    f[2] = ~f[2];
            3'd7:    f[1] = ~f[1];
            default: f = c;
        endcase
        return {f[5], f[3], f[2], f[1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ham_7_4_stat_cnt.sv
// ============================================================================
// Module  : ham_7_4_stat_cnt
// Brief   : Saturating statistics counter with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_7_4_stat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear has priority over increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ham_7_4_dec_pipe.sv
// ============================================================================
// Module  : ham_7_4_dec_pipe
// Brief   : Two-stage pipelined Hamming(7,4) SEC decoder with valid/ready and stats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_7_4_dec_pipe
    import ham_7_4_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  code7_t           code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output data4_t           data_out,
    output logic             corrected,
    output synd_t            syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    logic   v1;
    logic   v2;
    code7_t s1_code;
    synd_t  s1_synd;
    logic   s2_adv;
    logic   in_fire;
    logic   out_fire;

    assign s2_adv    = !v2 || out_ready;
    assign in_ready  = !v1 || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = v2 && out_ready;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_code <= '0;
            s1_synd <= '0;
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
            end
            if (in_fire) begin
                s1_code <= code_in;
                s1_synd <= ham74_syndrome(code_in);
            end
        end
    end

    // Stage 2 payload only moves when a new word is handed over, so a stalled result stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            data_out  <= '0;
            corrected <= 1'b0;
            syndrome  <= '0;
        end else begin
            if (s2_adv) begin
                v2 <= v1;
            end
            if (v1 && s2_adv) begin
                data_out  <= ham74_correct(s1_code, s1_synd);
                corrected <= (s1_synd != 3'd0);
                syndrome  <= s1_synd;
            end
        end
    end

    ham_7_4_stat_cnt #(
        .CNT_W (CNT_W)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_fire),
        .clr   (cnt_clr),
        .cnt   (word_cnt)
    );

    ham_7_4_stat_cnt #(
        .CNT_W (CNT_W)
    ) u_corr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_fire && corrected),
        .clr   (cnt_clr),
        .cnt   (corr_cnt)
    );

endmodule

`default_nettype wire
